// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The loader connects through the slave modport; the byte source / memory side uses master.
interface program_loader_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_last;
    logic                  byte_ready;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_write_data;

    modport master (
        output byte_valid, byte_data, byte_last,
        input  byte_ready, mem_write_enable, mem_address, mem_write_data
    );

    modport slave (
        input  byte_valid, byte_data, byte_last,
        output byte_ready, mem_write_enable, mem_address, mem_write_data
    );
endinterface

// File: rtl/program_loader.sv
// Packs a little-endian byte stream into 32-bit instruction words, writes them to
// sequential word addresses from BASE_ADDRESS, and holds the CPU until the program is complete.
module program_loader #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           MAX_WORDS    = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
    localparam int unsigned          COUNT_WIDTH  = $clog2(MAX_WORDS + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    program_loader_if.slave        bus,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] word_count
);
    typedef enum logic [2:0] {
        IDLE,
        RECEIVE,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            lane;
    logic [23:0]           word_buf;
    logic                  last_flag;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic                  ready;
    logic                  write_enable;
    logic                  accept;
    logic                  start_load;

    assign accept     = ready && bus.byte_valid;
    assign start_load = start && (state == IDLE || state == DONE || state == ERROR);

    assign bus.byte_ready       = ready;
    assign bus.mem_write_enable = write_enable;
    assign bus.mem_address      = addr_q;
    assign bus.mem_write_data   = data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        ready        = 1'b0;
        write_enable = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RECEIVE;
            end
            RECEIVE: begin
                ready = 1'b1;
                if (bus.byte_valid) begin
                    if (lane == 2'd3) begin
                        state_next = WRITE;
                    end else if (bus.byte_last) begin
                        state_next = ERROR;
                    end
                end
            end
            WRITE: begin
                write_enable = 1'b1;
                if (last_flag) begin
                    state_next = DONE;
                end else if (word_count == COUNT_WIDTH'(MAX_WORDS - 1)) begin
                    state_next = ERROR;
                end else begin
                    state_next = RECEIVE;
                end
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_next = RECEIVE;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_next = RECEIVE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The fourth byte bypasses word_buf and goes straight into the registered write word,
    // so address and data are already stable on the first cycle of WRITE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lane       <= '0;
            word_buf   <= '0;
            last_flag  <= 1'b0;
            word_count <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else if (start_load) begin
            lane       <= '0;
            word_buf   <= '0;
            last_flag  <= 1'b0;
            word_count <= '0;
        end else if (accept) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0: word_buf[7:0]   <= bus.byte_data;
                2'd1: word_buf[15:8]  <= bus.byte_data;
                2'd2: word_buf[23:16] <= bus.byte_data;
                default: begin
                    data_q    <= {bus.byte_data, word_buf};
                    addr_q    <= BASE_ADDRESS + (ADDR_WIDTH'(word_count) << 2);
                    last_flag <= bus.byte_last;
                end
            endcase
        end else if (state == WRITE) begin
            lane <= '0;
            if (word_count != COUNT_WIDTH'(MAX_WORDS)) begin
                word_count <= word_count + 1'b1;
            end
        end
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write side of instruction memory: takes a program as a byte stream and packs it into 32-bit little-endian RISC-V words.
- Writes each word to sequential word addresses starting at BASE_ADDRESS, in the memory the program counter fetches from.
- Holds the CPU (program counter / instruction register) in hold until a complete program has been written.

Parameters:
- ADDR_WIDTH, 32, width of mem_address.
- MAX_WORDS, 64, maximum program length in 32-bit words.
- BASE_ADDRESS, 0, byte address of the first written word.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a new load.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  program byte, least-significant byte of each word first.
- byte_last  input  1  qualifies byte_data as the final byte of the program.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_write_enable  output  1  one-cycle memory write strobe.
- mem_address  output  ADDR_WIDTH  byte address of the word being written.
- mem_write_data  output  32  assembled instruction word.
- cpu_hold  output  1  keeps the CPU stalled / in reset while high.
- done  output  1  program loaded successfully.
- error  output  1  load aborted.
- word_count  output  $clog2(MAX_WORDS+1)  number of words written in the current load.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0 except cpu_hold=1.
  - Byte lane, word index and assembly register clear.
  - Asserting reset mid-load aborts immediately; memory contents already written are left as-is.
- Byte handshake:
  - A byte transfers on a rising edge when byte_valid=1 and byte_ready=1.
  - byte_ready=1 only in RECEIVE; it is 0 in all other states, including WRITE.
- States:
  - IDLE:
    - start=1 -> RECEIVE; clears lane, word_count, done and error.
  - RECEIVE:
    - An accepted byte is placed at bits [8*lane+7 : 8*lane] and lane increments.
    - On lane 3 accept -> WRITE; the registered last flag = byte_last.
    - byte_last=1 on lanes 0-2 -> ERROR; no write is issued.
  - WRITE (exactly one cycle):
    - mem_write_enable=1.
    - mem_address = BASE_ADDRESS + 4*word_count.
    - mem_write_data = assembled word.
    - Next edge: word_count increments and lane clears to 0.
    - If last flag set -> DONE.
    - Else if word_count+1 == MAX_WORDS -> ERROR (overflow).
    - Else -> RECEIVE.
  - DONE:
    - done=1, cpu_hold=0.
    - start=1 -> RECEIVE and starts a new load; cpu_hold goes to 1 on that edge.
  - ERROR:
    - error=1, cpu_hold=1.
    - start=1 -> RECEIVE.
- start is ignored in RECEIVE and WRITE.
- cpu_hold=1 in every state except DONE.
- Latency: mem_write_enable asserts in the cycle after the 4th byte of a word is accepted. Sustained throughput is 4 bytes per 5 cycles.
- mem_address and mem_write_data are registered and stable throughout WRITE. Their value outside WRITE is don't-care, but both must be X-free after reset.
- word_count saturates at MAX_WORDS.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- mem_write_enable is never high for more than one consecutive cycle.

Test Plan:
- Reset then start; stream bytes 0x93,0x00,0x50,0x00 (last on 4th) -> one write: mem_address=0, mem_write_data=0x00500093; then done=1, cpu_hold=0, word_count=1.
- Three-word program 0x00500093, 0x00A00113, 0x002081B3 with byte_valid toggled every other cycle -> writes at addresses 0, 4, 8 with the correct words; byte_ready=0 during each WRITE cycle; done after the third write.
- byte_last on the 2nd byte of a word -> error=1, cpu_hold=1, no mem_write_enable; a following start re-enters RECEIVE with word_count=0, error=0.
- MAX_WORDS=2, stream 3 words without last -> exactly 2 writes (addresses 0, 4), then error=1 and byte_ready=0.
- Drive reset=0 asynchronously (not on a clock edge) after 2 bytes of word 1 -> outputs reset immediately: cpu_hold=1, done=0, no write. After release, start plus a full word writes at address 0 with no stale bytes in the word.
- start pulsed during RECEIVE and in DONE -> ignored during RECEIVE; in DONE it starts a fresh load with word_count=0 and cpu_hold=1.
